mul_sequencer: RTL
==================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001: The block SHALL have no parameters; operand width is selected at run time by is_8_bit.
REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: start  input  1  request a multiply; sampled only in IDLE.
REQ-005: is_8_bit  input  1  1 = 8x8->16 multiply on operand bits [7:0]; 0 = 16x16->32.
REQ-006: is_signed  input  1  1 = IMUL (two's complement); 0 = MUL.
REQ-007: multiplicand  input  16  operand A; captured at the accepting edge.
REQ-008: multiplier  input  16  operand B; captured at the accepting edge.
REQ-009: busy  output  1  high while an operation is in flight.
REQ-010: complete  output  1  single-cycle pulse; product valid.
REQ-011: product  output  32  result; held from complete until the next accepted start.
REQ-012: cf_of  output  1  value to write to both CF and OF, per x86 MUL/IMUL.

Function
REQ-013: The FSM SHALL have exactly three states: IDLE, RUN, FIXUP.
REQ-014: IDLE with start=1 at edge N SHALL:
  - capture both operands, is_8_bit and is_signed;
  - for signed operations, replace each operand by its magnitude and record sign = signA XOR signB, using bit 7 or bit 15 as the sign bit;
  - clear the accumulator and the bit counter;
  - enter RUN with busy=1.
REQ-015: Each RUN edge SHALL process one multiplier bit, LSB first (shift-add); RUN SHALL last exactly W edges, where W=8 if is_8_bit else 16, then enter FIXUP.
REQ-016: The FIXUP edge SHALL:
  - write product, two's-complement negated if the recorded sign=1;
  - set complete=1 and busy=0;
  - return to IDLE.
REQ-017: Latency: complete SHALL be high for exactly one cycle, following edge N+W+1 (i.e. 10 edges after acceptance for 8-bit, 18 for 16-bit, counting the accepting edge).
REQ-018: For 8-bit operations, the result SHALL occupy product[15:0] and product[31:16] SHALL be 0.
REQ-019: cf_of, unsigned case: set to 1 iff the upper half is nonzero (product[15:8] for 8-bit, product[31:16] for 16-bit).
REQ-020: cf_of, signed case: set to 1 iff the upper half is not the sign extension of the lower half's MSB.
REQ-021: cf_of SHALL be registered alongside product and held with it.
REQ-022: A start asserted while busy=1 SHALL be ignored, with no effect on state, operands or outputs.
REQ-023: A start asserted in the cycle complete is high SHALL be accepted, since the FSM is in IDLE; product and cf_of SHALL then hold until the new FIXUP edge.
REQ-024: Operand inputs SHALL be don't-care at all times except the accepting edge.
REQ-025: The most-negative signed operands (0x80 for 8-bit, 0x8000 for 16-bit) SHALL produce correct magnitudes; the internal magnitude width SHALL be 16 bits unsigned.

Reset
REQ-026: While reset is high, the block SHALL hold:
  - state = IDLE;
  - busy = 0, complete = 0, cf_of = 0, product = 0;
  - accumulator, counter and captured operands = 0.
REQ-027: Reset asserted mid-RUN or mid-FIXUP SHALL abort the operation, with no complete pulse afterwards.
REQ-028: After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-029: 16-bit unsigned 0xFFFF x 0xFFFF -> product=0xFFFE0001, cf_of=1, complete 18 edges after the accepting edge (counting it), single-cycle.
REQ-030: 8-bit signed 0xFF x 0x02 -> product=0x0000FFFE, cf_of=0; 8-bit unsigned 0x10 x 0x10 -> product=0x00000100, cf_of=1.
REQ-031: 16-bit signed 0x8000 x 0x8000 -> product=0x40000000, cf_of=1; 16-bit signed 0xFFFF x 0x0003 -> product=0xFFFFFFFD, cf_of=0.
REQ-032: Start pulsed again at RUN cycle 3 with different operands -> ignored; the original result completes at the nominal cycle.
REQ-033: Reset asserted at RUN cycle 5 -> all outputs 0 immediately; no complete pulse; a subsequent 8-bit start 0x03 x 0x04 -> product=0x0000000C, cf_of=0.
REQ-034: Back-to-back: start held high through complete -> second operation accepted in the complete cycle; two complete pulses exactly W+2 cycles apart.

Source files
------------

// File: rtl/mul_sequencer_if.sv
// Handshake and result bus for the shift-add multiply sequencer.
interface mul_sequencer_if;
   logic        start;
   logic        is_8_bit;
   logic        is_signed;
   logic [15:0] multiplicand;
   logic [15:0] multiplier;
   logic        busy;
   logic        complete;
   logic [31:0] product;
   logic        cf_of;

   modport master (
      output start, is_8_bit, is_signed, multiplicand, multiplier,
      input  busy, complete, product, cf_of
   );

   modport slave (
      input  start, is_8_bit, is_signed, multiplicand, multiplier,
      output busy, complete, product, cf_of
   );
endinterface

// File: rtl/mul_sequencer.sv
// x86 MUL/IMUL shift-add sequencer: 8x8 or 16x16, complete pulses W+2 edges after accept.
// No backpressure; start is ignored while busy and product/cf_of hold until the next result.
module mul_sequencer (
   input  logic              clk,
   input  logic              reset,
   mul_sequencer_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

   state_t      state, state_nxt;
   logic [31:0] acc;
   logic [31:0] mcand_sh;
   logic [15:0] mplier;
   logic [4:0]  cnt;
   logic        is8_q;
   logic        signed_q;
   logic        sign_q;
   logic        complete_q;
   logic [31:0] product_q;
   logic        cf_of_q;

   // Operand magnitudes; 16 bits unsigned so 0x80 and 0x8000 negate exactly.
   logic [7:0]  a_n8, b_n8;
   logic [15:0] a_n16, b_n16;
   logic        a_neg, b_neg;
   logic [15:0] a_mag, b_mag;
   logic        last_bit;
   logic [31:0] res_full, res;
   logic        cf_nxt;

   always_comb begin
      a_n8  = ~bus.multiplicand[7:0] + 8'd1;
      b_n8  = ~bus.multiplier[7:0] + 8'd1;
      a_n16 = ~bus.multiplicand + 16'd1;
      b_n16 = ~bus.multiplier + 16'd1;
      a_neg = bus.is_signed & (bus.is_8_bit ? bus.multiplicand[7] : bus.multiplicand[15]);
      b_neg = bus.is_signed & (bus.is_8_bit ? bus.multiplier[7] : bus.multiplier[15]);
      if (bus.is_8_bit) begin
         a_mag = {8'h00, (a_neg ? a_n8 : bus.multiplicand[7:0])};
         b_mag = {8'h00, (b_neg ? b_n8 : bus.multiplier[7:0])};
      end else begin
         a_mag = a_neg ? a_n16 : bus.multiplicand;
         b_mag = b_neg ? b_n16 : bus.multiplier;
      end
   end

   always_comb begin
      last_bit = (cnt == (is8_q ? 5'd7 : 5'd15));
      res_full = sign_q ? (~acc + 32'd1) : acc;
      res      = is8_q ? {16'h0000, res_full[15:0]} : res_full;
      if (is8_q)
         cf_nxt = signed_q ? (res[15:8] != {8{res[7]}}) : (res[15:8] != 8'h00);
      else
         cf_nxt = signed_q ? (res[31:16] != {16{res[15]}}) : (res[31:16] != 16'h0000);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_bit)  state_nxt = FIXUP;
         FIXUP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc        <= '0;
         mcand_sh   <= '0;
         mplier     <= '0;
         cnt        <= '0;
         is8_q      <= 1'b0;
         signed_q   <= 1'b0;
         sign_q     <= 1'b0;
         complete_q <= 1'b0;
         product_q  <= '0;
         cf_of_q    <= 1'b0;
      end else begin
         complete_q <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               mcand_sh <= {16'h0000, a_mag};
               mplier   <= b_mag;
               acc      <= '0;
               cnt      <= '0;
               is8_q    <= bus.is_8_bit;
               signed_q <= bus.is_signed;
               sign_q   <= a_neg ^ b_neg;
            end
            RUN: begin
               if (mplier[0]) acc <= acc + mcand_sh;
               mcand_sh <= mcand_sh << 1;
               mplier   <= mplier >> 1;
               cnt      <= cnt + 5'd1;
            end
            FIXUP: begin
               product_q  <= res;
               cf_of_q    <= cf_nxt;
               complete_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.complete = complete_q;
   assign bus.product  = product_q;
   assign bus.cf_of    = cf_of_q;
endmodule
